// File: rtl/instr_fetch_if.sv
// Fetch-stage bundle: PC control, instruction memory read port,
// decoder handshake and branch redirect.
interface instr_fetch_if;
  logic [7:0] pc_cur;
  logic       pc_inc_en;
  logic [7:0] pc_load_val;

  logic [7:0] mem_addr;
  logic       mem_rd_req;
  logic       mem_rd_valid;
  logic [7:0] mem_rd_data;

  logic [7:0] ir_opcode;
  logic [7:0] ir_operand;
  logic [7:0] ir_pc;
  logic       ir_len;
  logic       ir_valid;
  logic       ir_ready;

  logic       redirect;
  logic [7:0] redirect_target;

  modport master (
    input  pc_cur,
    input  mem_rd_valid,
    input  mem_rd_data,
    input  ir_ready,
    input  redirect,
    input  redirect_target,
    output pc_inc_en,
    output pc_load_val,
    output mem_addr,
    output mem_rd_req,
    output ir_opcode,
    output ir_operand,
    output ir_pc,
    output ir_len,
    output ir_valid
  );

  modport slave (
    output pc_cur,
    output mem_rd_valid,
    output mem_rd_data,
    output ir_ready,
    output redirect,
    output redirect_target,
    input  pc_inc_en,
    input  pc_load_val,
    input  mem_addr,
    input  mem_rd_req,
    input  ir_opcode,
    input  ir_operand,
    input  ir_pc,
    input  ir_len,
    input  ir_valid
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: byte-wise fetch of 1/2-byte instructions,
// single outstanding memory read, decoder handshake and redirect flush.
module instr_fetch #(
  parameter int OPERAND_BIT = 7
) (
  input logic          clk,
  input logic          rst,
  instr_fetch_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    REQ_OP,
    WAIT_OP,
    REQ_ARG,
    WAIT_ARG,
    HOLD,
    DRAIN
  } state_t;

  state_t     state;
  logic [7:0] addr_q;
  logic [7:0] opcode_q;
  logic [7:0] operand_q;
  logic [7:0] ir_pc_q;
  logic       len_q;

  logic is_req;
  logic is_wait;

  assign is_req  = (state == REQ_OP) || (state == REQ_ARG);
  assign is_wait = (state == WAIT_OP) || (state == WAIT_ARG);

  assign bus.mem_rd_req = is_req;
  assign bus.mem_addr   = is_req ? bus.pc_cur : addr_q;

  // PC advances at the edge the byte is latched, unless flushed
  assign bus.pc_inc_en   = is_wait && bus.mem_rd_valid
                           && !bus.redirect;
  assign bus.pc_load_val = bus.redirect ? bus.redirect_target
                                        : bus.pc_cur;

  assign bus.ir_valid   = (state == HOLD);
  assign bus.ir_opcode  = opcode_q;
  assign bus.ir_operand = operand_q;
  assign bus.ir_pc      = ir_pc_q;
  assign bus.ir_len     = len_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      addr_q    <= 8'h00;
      opcode_q  <= 8'h00;
      operand_q <= 8'h00;
      ir_pc_q   <= 8'h00;
      len_q     <= 1'b0;
    end else begin
      if (is_req)
        addr_q <= bus.pc_cur;
      if (state == REQ_OP)
        ir_pc_q <= bus.pc_cur;

      if (bus.redirect && state != IDLE) begin
        // an in-flight read must be swallowed before refetching
        if (state == DRAIN)
          state <= bus.mem_rd_valid ? REQ_OP : DRAIN;
        else if (is_req || (is_wait && !bus.mem_rd_valid))
          state <= DRAIN;
        else
          state <= REQ_OP;
      end else begin
        unique case (state)
          IDLE:    state <= REQ_OP;
          REQ_OP:  state <= WAIT_OP;
          REQ_ARG: state <= WAIT_ARG;
          WAIT_OP: begin
            if (bus.mem_rd_valid) begin
              opcode_q <= bus.mem_rd_data;
              if (bus.mem_rd_data[OPERAND_BIT]) begin
                state <= REQ_ARG;
              end else begin
                operand_q <= 8'h00;
                len_q     <= 1'b0;
                state     <= HOLD;
              end
            end
          end
          WAIT_ARG: begin
            if (bus.mem_rd_valid) begin
              operand_q <= bus.mem_rd_data;
              len_q     <= 1'b1;
              state     <= HOLD;
            end
          end
          HOLD: begin
            if (bus.ir_ready)
              state <= REQ_OP;
          end
          DRAIN: begin
            if (bus.mem_rd_valid)
              state <= REQ_OP;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a PC model and a
// variable-latency instruction memory model.
module tb_instr_fetch;

  logic clk = 1'b0;
  logic rst;

  instr_fetch_if bus ();

  instr_fetch #(.OPERAND_BIT(7)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [7:0] mem [256];
  int         lat   = 1;
  logic       mv    = 1'b0;
  logic [7:0] md    = 8'h00;
  logic [7:0] raddr = 8'h00;
  int         cnt   = 0;

  assign bus.mem_rd_valid = mv;
  assign bus.mem_rd_data  = md;

  always @(posedge clk or posedge rst) begin
    if (rst)
      bus.pc_cur <= 8'h00;
    else if (bus.pc_inc_en)
      bus.pc_cur <= bus.pc_cur + 8'd1;
    else
      bus.pc_cur <= bus.pc_load_val;
  end

  // memory ignores rst so a response can land after reset
  always @(posedge clk) begin
    mv <= 1'b0;
    if (bus.mem_rd_req) begin
      raddr <= bus.mem_addr;
      if (lat <= 1) begin
        mv  <= 1'b1;
        md  <= mem[bus.mem_addr];
        cnt <= 0;
      end else begin
        cnt <= lat - 1;
      end
    end else if (cnt == 1) begin
      mv  <= 1'b1;
      md  <= mem[raddr];
      cnt <= 0;
    end else if (cnt > 1) begin
      cnt <= cnt - 1;
    end
  end

  int         inc_cnt = 0;
  logic [7:0] req_q[$];

  always @(negedge clk) begin
    if (bus.pc_inc_en)
      inc_cnt++;
    if (bus.mem_rd_req)
      req_q.push_back(bus.mem_addr);
  end

  task automatic do_redirect(input logic [7:0] t);
    bus.redirect        = 1'b1;
    bus.redirect_target = t;
    @(posedge clk);
    #1;
    bus.redirect = 1'b0;
  endtask

  task automatic get_instr(
    output logic [7:0] op,
    output logic [7:0] arg,
    output logic [7:0] ipc,
    output logic       len,
    output bit         ok
  );
    ok  = 1'b0;
    op  = 8'h00;
    arg = 8'h00;
    ipc = 8'h00;
    len = 1'b0;
    bus.ir_ready = 1'b1;
    for (int n = 0; n < 60 && !ok; n++) begin
      @(negedge clk);
      if (bus.ir_valid) begin
        op  = bus.ir_opcode;
        arg = bus.ir_operand;
        ipc = bus.ir_pc;
        len = bus.ir_len;
        ok  = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    bus.ir_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.ir_ready = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_target = 8'h00;
    repeat (2) @(negedge clk);
    checks++; if (bus.ir_valid !== 1'b0) begin errors++; $display("FAIL rst_ir_valid got %b want 0", bus.ir_valid); end
    checks++; if (bus.mem_rd_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b want 0", bus.mem_rd_req); end
    checks++; if (bus.mem_addr !== 8'h00) begin errors++; $display("FAIL rst_addr got %h want 00", bus.mem_addr); end
    checks++; if (bus.pc_inc_en !== 1'b0) begin errors++; $display("FAIL rst_inc got %b want 0", bus.pc_inc_en); end
    checks++; if (bus.ir_opcode !== 8'h00) begin errors++; $display("FAIL rst_op got %h want 00", bus.ir_opcode); end
    checks++; if (bus.ir_operand !== 8'h00) begin errors++; $display("FAIL rst_arg got %h want 00", bus.ir_operand); end
    checks++; if (bus.ir_pc !== 8'h00) begin errors++; $display("FAIL rst_irpc got %h want 00", bus.ir_pc); end
    checks++; if (bus.ir_len !== 1'b0) begin errors++; $display("FAIL rst_len got %b want 0", bus.ir_len); end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_one_byte;
    logic [7:0] op, arg, ipc;
    logic len;
    bit ok;
    int i0, r0;
    lat = 1;
    i0 = inc_cnt;
    r0 = req_q.size();
    get_instr(op, arg, ipc, len, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b1_timeout got none want instr"); end
    checks++; if (op !== 8'h12) begin errors++; $display("FAIL b1_op got %h want 12", op); end
    checks++; if (arg !== 8'h00) begin errors++; $display("FAIL b1_arg got %h want 00", arg); end
    checks++; if (len !== 1'b0) begin errors++; $display("FAIL b1_len got %b want 0", len); end
    checks++; if (ipc !== 8'h00) begin errors++; $display("FAIL b1_pc got %h want 00", ipc); end
    checks++; if (inc_cnt - i0 != 1) begin errors++; $display("FAIL b1_inc got %0d want 1", inc_cnt - i0); end
    checks++; if (req_q.size() <= r0 || req_q[r0] !== 8'h00) begin errors++; $display("FAIL b1_req0 got %0d reqs want addr 00", req_q.size() - r0); end
    checks++; if (bus.mem_rd_req !== 1'b1 || bus.mem_addr !== 8'h01) begin errors++; $display("FAIL b1_next got req=%b addr=%h want 1/01", bus.mem_rd_req, bus.mem_addr); end
  endtask

  task automatic test_two_byte;
    logic [7:0] op, arg, ipc;
    logic len;
    bit ok;
    int i0, r0;
    lat = 1;
    do_redirect(8'h05);
    i0 = inc_cnt;
    r0 = req_q.size();
    get_instr(op, arg, ipc, len, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2_timeout got none want instr"); end
    checks++; if (op !== 8'h83) begin errors++; $display("FAIL b2_op got %h want 83", op); end
    checks++; if (arg !== 8'h4A) begin errors++; $display("FAIL b2_arg got %h want 4a", arg); end
    checks++; if (len !== 1'b1) begin errors++; $display("FAIL b2_len got %b want 1", len); end
    checks++; if (ipc !== 8'h05) begin errors++; $display("FAIL b2_pc got %h want 05", ipc); end
    checks++; if (inc_cnt - i0 != 2) begin errors++; $display("FAIL b2_inc got %0d want 2", inc_cnt - i0); end
    checks++; if (req_q.size() < r0 + 2 || req_q[r0] !== 8'h05 || req_q[r0+1] !== 8'h06) begin errors++; $display("FAIL b2_reqs got %0d reqs want 05,06", req_q.size() - r0); end
    checks++; if (bus.pc_cur !== 8'h07) begin errors++; $display("FAIL b2_pcafter got %h want 07", bus.pc_cur); end
  endtask

  task automatic test_stall;
    bit seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      seen = bus.ir_valid;
    end
    checks++; if (!seen) begin errors++; $display("FAIL st_timeout got none want hold"); end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (bus.ir_valid !== 1'b1 || bus.ir_opcode !== 8'hC5 || bus.ir_operand !== 8'h3C || bus.ir_pc !== 8'h07 || bus.ir_len !== 1'b1) begin
        errors++;
        $display("FAIL st_ir cyc%0d got v=%b %h %h %h %b want 1 c5 3c 07 1", c, bus.ir_valid, bus.ir_opcode, bus.ir_operand, bus.ir_pc, bus.ir_len);
      end
      checks++; if (bus.mem_rd_req !== 1'b0 || bus.pc_inc_en !== 1'b0) begin errors++; $display("FAIL st_quiet cyc%0d got req=%b inc=%b want 0/0", c, bus.mem_rd_req, bus.pc_inc_en); end
      checks++; if (bus.pc_load_val !== 8'h09 || bus.pc_cur !== 8'h09) begin errors++; $display("FAIL st_pc cyc%0d got load=%h pc=%h want 09", c, bus.pc_load_val, bus.pc_cur); end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_redirect_wait_arg;
    logic [7:0] op, arg, ipc;
    logic len;
    bit ok;
    bit seen = 1'b0;
    int i0, r0;
    lat = 3;
    do_redirect(8'h20);
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      seen = bus.mem_rd_req && bus.mem_addr == 8'h21;
    end
    checks++; if (!seen) begin errors++; $display("FAIL rd_timeout got none want req 21"); end
    @(posedge clk);
    #1;
    i0 = inc_cnt;
    r0 = req_q.size();
    do_redirect(8'h40);
    lat = 1;
    checks++; if (bus.pc_cur !== 8'h40) begin errors++; $display("FAIL rd_pc got %h want 40", bus.pc_cur); end
    get_instr(op, arg, ipc, len, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rd_instr_timeout got none want instr"); end
    checks++; if (op !== 8'h2B || ipc !== 8'h40 || len !== 1'b0) begin errors++; $display("FAIL rd_instr got %h@%h len %b want 2b@40 len 0", op, ipc, len); end
    checks++; if (inc_cnt - i0 != 1) begin errors++; $display("FAIL rd_inc got %0d want 1", inc_cnt - i0); end
    checks++; if (req_q.size() <= r0 || req_q[r0] !== 8'h40) begin errors++; $display("FAIL rd_req got %0d reqs want first 40", req_q.size() - r0); end
  endtask

  task automatic test_wrap;
    logic [7:0] op, arg, ipc;
    logic len;
    bit ok;
    int r0;
    lat = 1;
    do_redirect(8'hFF);
    r0 = req_q.size();
    get_instr(op, arg, ipc, len, ok);
    checks++; if (!ok) begin errors++; $display("FAIL wr_timeout got none want instr"); end
    checks++; if (op !== 8'h90 || arg !== 8'h12) begin errors++; $display("FAIL wr_bytes got %h %h want 90 12", op, arg); end
    checks++; if (ipc !== 8'hFF || len !== 1'b1) begin errors++; $display("FAIL wr_pclen got %h %b want ff 1", ipc, len); end
    checks++; if (req_q.size() < r0 + 2 || req_q[r0] !== 8'hFF || req_q[r0+1] !== 8'h00) begin errors++; $display("FAIL wr_reqs got %0d reqs want ff,00", req_q.size() - r0); end
    checks++; if (bus.pc_cur !== 8'h01) begin errors++; $display("FAIL wr_pcafter got %h want 01", bus.pc_cur); end
  endtask

  task automatic test_back_to_back;
    int t[3];
    logic [7:0] o[3];
    int got = 0;
    lat = 1;
    do_redirect(8'h10);
    bus.ir_ready = 1'b1;
    for (int c = 0; c < 40 && got < 3; c++) begin
      @(negedge clk);
      if (bus.ir_valid) begin
        t[got] = c;
        o[got] = bus.ir_opcode;
        got++;
      end
    end
    @(posedge clk);
    #1;
    bus.ir_ready = 1'b0;
    checks++; if (got != 3) begin errors++; $display("FAIL bb_count got %0d want 3", got); end
    checks++; if (o[0] !== 8'h11 || o[1] !== 8'h22 || o[2] !== 8'h33) begin errors++; $display("FAIL bb_ops got %h %h %h want 11 22 33", o[0], o[1], o[2]); end
    checks++; if (t[1] - t[0] != 3 || t[2] - t[1] != 3) begin errors++; $display("FAIL bb_rate got %0d %0d want 3 3", t[1] - t[0], t[2] - t[1]); end
  endtask

  task automatic test_reset_mid;
    logic [7:0] op, arg, ipc;
    logic len;
    bit ok;
    bit seen = 1'b0;
    int i0, r0;
    lat = 3;
    do_redirect(8'h30);
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      seen = bus.mem_rd_req && bus.mem_addr == 8'h30;
    end
    checks++; if (!seen) begin errors++; $display("FAIL rm_timeout got none want req 30"); end
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++; if (bus.ir_valid !== 1'b0 || bus.mem_rd_req !== 1'b0 || bus.mem_addr !== 8'h00) begin errors++; $display("FAIL rm_ctl got v=%b req=%b addr=%h want 0 0 00", bus.ir_valid, bus.mem_rd_req, bus.mem_addr); end
    checks++; if (bus.ir_opcode !== 8'h00 || bus.ir_operand !== 8'h00 || bus.ir_pc !== 8'h00 || bus.ir_len !== 1'b0) begin errors++; $display("FAIL rm_ir got %h %h %h %b want 00 00 00 0", bus.ir_opcode, bus.ir_operand, bus.ir_pc, bus.ir_len); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    lat = 1;
    i0 = inc_cnt;
    r0 = req_q.size();
    get_instr(op, arg, ipc, len, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rm_instr_timeout got none want instr"); end
    checks++; if (op !== 8'h12 || arg !== 8'h00 || ipc !== 8'h00 || len !== 1'b0) begin errors++; $display("FAIL rm_instr got %h %h %h %b want 12 00 00 0", op, arg, ipc, len); end
    checks++; if (inc_cnt - i0 != 1) begin errors++; $display("FAIL rm_inc got %0d want 1", inc_cnt - i0); end
    checks++; if (req_q.size() <= r0 || req_q[r0] !== 8'h00) begin errors++; $display("FAIL rm_req got %0d reqs want first 00", req_q.size() - r0); end
  endtask

  initial begin
    for (int a = 0; a < 256; a++)
      mem[a] = 8'h00;
    mem[8'h00] = 8'h12;
    mem[8'h05] = 8'h83;
    mem[8'h06] = 8'h4A;
    mem[8'h07] = 8'hC5;
    mem[8'h08] = 8'h3C;
    mem[8'h10] = 8'h11;
    mem[8'h11] = 8'h22;
    mem[8'h12] = 8'h33;
    mem[8'h20] = 8'h81;
    mem[8'h21] = 8'h99;
    mem[8'h30] = 8'hEE;
    mem[8'h40] = 8'h2B;
    mem[8'hFF] = 8'h90;

    test_reset();
    test_one_byte();
    test_two_byte();
    test_stall();
    test_redirect_wait_arg();
    test_wrap();
    test_back_to_back();
    test_reset_mid();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage directly downstream of the 8-bit program counter.
- Reads the current PC and issues byte reads to instruction memory (single outstanding request, variable latency).
- Assembles 1- or 2-byte instructions and presents them to the decoder over a valid/ready handshake.
- Drives the PC's increment enable and load value, so the PC advances only on consumed bytes and reloads on branch redirects.

Parameters:
- OPERAND_BIT, 7: opcode bit that marks a 2-byte instruction (1 = operand byte follows).

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- pc_cur  in  8  current PC value from the program counter
- pc_inc_en  out  1  increment PC at next edge
- pc_load_val  out  8  value the PC loads when pc_inc_en=0
- mem_addr  out  8  read address
- mem_rd_req  out  1  one-cycle read request pulse
- mem_rd_valid  in  1  read data valid; at most one per request, at least 1 cycle after the request
- mem_rd_data  in  8  read data
- ir_opcode  out  8  instruction opcode byte
- ir_operand  out  8  operand byte; 0x00 for 1-byte instructions
- ir_pc  out  8  address of the opcode byte
- ir_len  out  1  0 = 1-byte instruction, 1 = 2-byte instruction
- ir_valid  out  1  instruction available to the decoder
- ir_ready  in  1  decoder accepts the instruction
- redirect  in  1  branch/jump taken; flush and refetch
- redirect_target  in  8  new PC for the redirect

Behaviour:
- Reset (async): state=IDLE. pc_inc_en=0, mem_rd_req=0, ir_valid=0, ir_opcode/ir_operand/ir_pc/ir_len=0, mem_addr=0x00.
- States:
  - IDLE: always goes to REQ_OP next cycle.
  - REQ_OP: mem_rd_req=1, mem_addr=pc_cur, ir_pc<=pc_cur. Next state WAIT_OP.
  - WAIT_OP: on mem_rd_valid, ir_opcode<=data. If data[OPERAND_BIT]=1, go to REQ_ARG; else ir_operand<=0, ir_len<=0, go to HOLD.
  - REQ_ARG: mem_rd_req=1, mem_addr=pc_cur. Next state WAIT_ARG.
  - WAIT_ARG: on mem_rd_valid, ir_operand<=data, ir_len<=1, go to HOLD.
  - HOLD: ir_valid=1. On ir_ready, go to REQ_OP. ir_* outputs are stable while ir_valid=1 and ready is low.
  - DRAIN: wait for the orphaned response, discard it, then go to REQ_OP.
- pc_inc_en is combinational: 1 only in WAIT_OP/WAIT_ARG when mem_rd_valid=1 and redirect=0. The PC advances at the same edge the byte is latched, so REQ_ARG sees the incremented PC with no bubble.
- pc_load_val:
  - redirect_target when redirect=1.
  - Otherwise pc_cur, so the PC holds whenever pc_inc_en=0.
- mem_rd_req is exactly one cycle per byte. mem_addr is held after the request until the next request.
- Redirect, in any state except IDLE:
  - pc_inc_en=0 and pc_load_val=redirect_target, so the PC loads the target at that edge.
  - ir_valid drops next cycle and the held instruction is discarded, even if ir_ready=1 in the same cycle.
  - Next state is DRAIN if a request is outstanding and mem_rd_valid=0 this cycle (WAIT_OP/WAIT_ARG, or REQ_OP/REQ_ARG with the request issuing this cycle). Otherwise REQ_OP.
  - Redirect coincident with mem_rd_valid: the byte is discarded and the PC does not increment.
  - Redirect during DRAIN: PC reloads and the state stays DRAIN.
  - Redirect in IDLE: PC loads the target, then REQ_OP as normal.
- Wrap-around: the operand of a 2-byte opcode at 0xFF is fetched from 0x00 via natural PC wrap, and ir_pc=0xFF.
- Throughput: 1-byte instruction takes at least 3 cycles (REQ, WAIT, HOLD); 2-byte takes at least 5.
- Reset mid-operation: immediate return to reset values. A late mem_rd_valid arriving in IDLE/REQ_OP is ignored.

Test Plan:
- Reset then memory 0x00=0x12, latency 1, ir_ready=1 -> mem_rd_req at addr 0x00; ir_valid with opcode 0x12, operand 0x00, ir_len=0, ir_pc=0x00; exactly one pc_inc_en pulse; next request at addr 0x01.
- Memory 0x05=0x83, 0x06=0x4A, pc=0x05 -> ir_opcode=0x83, ir_operand=0x4A, ir_len=1, ir_pc=0x05; two pc_inc_en pulses; PC=0x07 afterwards.
- ir_ready held low 10 cycles in HOLD -> ir_* stable, no mem_rd_req, pc_inc_en=0, pc_load_val=pc_cur, PC unchanged.
- Redirect to 0x40 while in WAIT_ARG with latency 3 -> PC=0x40 next cycle; orphan response dropped with no pc_inc_en; next request at addr 0x40; no instruction emitted for the flushed fetch.
- Opcode 0x90 at 0xFF -> operand read at addr 0x00; ir_pc=0xFF, ir_len=1; PC=0x01 afterwards.
- rst asserted mid WAIT_OP with the response arriving after release -> outputs return to reset values immediately; late mem_rd_valid ignored; first fetch from PC 0x00.
